alu8_issue_seq: RTL and testbench

- Operand/issue stage directly upstream of the 8-bit ALU (alu8, combinational: A, B, F in; Q, Cout out).
- Accepts one instruction at a time over a valid/ready handshake and reads operands from a small internal register file.
- Drives the ALU, captures Q/Cout, writes the result back to the register file, and presents it downstream over a second valid/ready handshake.
- Also keeps carry/zero flags and a retired-op counter.

---
 rtl/alu8_issue_seq.sv | 108 ++++++++++
 tb/tb_alu8_issue_seq.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu8_issue_seq.sv
// Operand/issue stage feeding a combinational 8-bit ALU: reads operands from a
// small register file, captures the ALU result, writes it back and hands it downstream.
//
// state | meaning
// IDLE  | ready for an instruction; operands latched on accept
// EXEC  | latched operands drive the ALU; result captured and written back at cycle end
// HOLD  | result presented downstream until out_ready
module alu8_issue_seq #(
  parameter int ADDR_W = 2,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_op,
  input  logic [ADDR_W-1:0] in_rd,
  input  logic [ADDR_W-1:0] in_rs1,
  input  logic [ADDR_W-1:0] in_rs2,
  input  logic              in_imm_en,
  input  logic [7:0]        in_imm,
  output logic [7:0]        alu_a,
  output logic [7:0]        alu_b,
  output logic [2:0]        alu_f,
  input  logic [7:0]        alu_q,
  input  logic              alu_cout,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_data,
  output logic [ADDR_W-1:0] out_rd,
  output logic              out_carry,
  output logic              out_zero,
  output logic [CNT_W-1:0]  ops_done,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [7:0]        dbg_data
);

  localparam int NREG = 1 << ADDR_W;

  typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_t;

  state_t            state, state_nxt;
  logic [7:0]        rf [NREG];
  logic [ADDR_W-1:0] rd_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = EXEC;
      EXEC:    state_nxt = HOLD;
      HOLD:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign in_ready = (state == IDLE);
  assign dbg_data = rf[dbg_addr];

  // The alu_* registers double as the latched operands, so the ALU inputs are
  // glitch-free for the whole EXEC cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) rf[i] <= 8'h00;
      rd_q      <= '0;
      alu_a     <= 8'h00;
      alu_b     <= 8'h00;
      alu_f     <= 3'b000;
      out_valid <= 1'b0;
      out_data  <= 8'h00;
      out_rd    <= '0;
      out_carry <= 1'b0;
      out_zero  <= 1'b0;
      ops_done  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            alu_a <= rf[in_rs1];
            alu_b <= in_imm_en ? in_imm : rf[in_rs2];
            alu_f <= in_op;
            rd_q  <= in_rd;
          end
        end
        EXEC: begin
          rf[rd_q]  <= alu_q;
          out_data  <= alu_q;
          out_carry <= alu_cout;
          out_zero  <= (alu_q == 8'h00);
          out_rd    <= rd_q;
          out_valid <= 1'b1;
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            ops_done  <= ops_done + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu8_issue_seq.sv
// Self-checking bench for alu8_issue_seq: directed vector table, randomized
// instructions against a register-file reference model, and multi-cycle corner cases.
module tb_alu8_issue_seq;
  localparam int ADDR_W = 2;
  localparam int CNT_W  = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid, in_ready;
  logic [2:0]        in_op;
  logic [ADDR_W-1:0] in_rd, in_rs1, in_rs2;
  logic              in_imm_en;
  logic [7:0]        in_imm;
  logic [7:0]        alu_a, alu_b;
  logic [2:0]        alu_f;
  logic [7:0]        alu_q;
  logic              alu_cout;
  logic              out_valid, out_ready;
  logic [7:0]        out_data;
  logic [ADDR_W-1:0] out_rd;
  logic              out_carry, out_zero;
  logic [CNT_W-1:0]  ops_done;
  logic [ADDR_W-1:0] dbg_addr;
  logic [7:0]        dbg_data;

  alu8_issue_seq #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_rd(in_rd),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm_en(in_imm_en), .in_imm(in_imm),
    .alu_a(alu_a), .alu_b(alu_b), .alu_f(alu_f), .alu_q(alu_q), .alu_cout(alu_cout),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_rd(out_rd),
    .out_carry(out_carry), .out_zero(out_zero), .ops_done(ops_done),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  // Arithmetic definition of the ALU, returned as {cout, q}.
  function automatic logic [8:0] ref_alu(input logic [2:0] f, input logic [7:0] a, input logic [7:0] b);
    case (f)
      3'd0:    return {1'b0, a} + {1'b0, b};
      3'd1:    return {(a < b), 8'(a - b)};
      3'd2:    return {1'b0, a | b};
      3'd3:    return {1'b0, a & b};
      3'd4:    return {1'b0, a ^ b};
      3'd5:    return {1'b0, ~a};
      3'd6:    return {1'b0, 8'(a << 1)};
      default: return {1'b0, 8'($signed(a) >>> 1)};
    endcase
  endfunction

  always_comb {alu_cout, alu_q} = ref_alu(alu_f, alu_a, alu_b);

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  logic [7:0] ref_rf [4];
  int         ref_ops;
  logic [7:0] e_a, e_b, e_q;
  logic       e_c;

  typedef struct {
    logic [2:0] op;
    logic [1:0] rd;
    logic [1:0] rs1;
    logic [1:0] rs2;
    logic       imm_en;
    logic [7:0] imm;
    logic [7:0] q;
    logic       c;
  } vec_t;
  vec_t tbl [9];

  task automatic drive(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                       input logic [1:0] rs2, input logic imm_en, input logic [7:0] imm);
    in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm_en = imm_en; in_imm = imm;
    in_valid = 1'b1;
  endtask

  task automatic run_instr(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                           input logic [1:0] rs2, input logic imm_en, input logic [7:0] imm,
                           input bit use_tbl, input logic [7:0] t_q, input logic t_c,
                           input int hold);
    logic [8:0] r;
    int w;
    w = 0;
    @(negedge clk);
    while (!in_ready && w < 20) begin @(negedge clk); w++; end
    chk("in_ready_wait", in_ready, 1);
    drive(op, rd, rs1, rs2, imm_en, imm);
    e_a = ref_rf[rs1];
    e_b = imm_en ? imm : ref_rf[rs2];
    r   = ref_alu(op, e_a, e_b);
    e_q = use_tbl ? t_q : r[7:0];
    e_c = use_tbl ? t_c : r[8];
    @(negedge clk);
    in_valid = 1'b0;
    chk("exec_in_ready", in_ready, 0);
    chk("exec_out_valid", out_valid, 0);
    chk("alu_a", alu_a, e_a);
    chk("alu_b", alu_b, e_b);
    chk("alu_f", alu_f, op);
    @(negedge clk);
    chk("out_valid", out_valid, 1);
    chk("out_data", out_data, e_q);
    chk("out_carry", out_carry, e_c);
    chk("out_zero", out_zero, (e_q == 8'h00));
    chk("out_rd", out_rd, rd);
    dbg_addr = rd;
    #1 chk("dbg_wb", dbg_data, e_q);
    ref_rf[rd] = e_q;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", out_valid, 1);
      chk("hold_data", out_data, e_q);
      chk("hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    ref_ops++;
    chk("done_valid", out_valid, 0);
    chk("ops_done", ops_done, 16'(ref_ops));
    chk("done_in_ready", in_ready, 1);
  endtask

  task automatic clear_ref();
    for (int i = 0; i < 4; i++) ref_rf[i] = 8'h00;
    ref_ops = 0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] pa;
    tbl[0] = '{3'd0, 2'd1, 2'd0, 2'd0, 1'b1, 8'h7F, 8'h7F, 1'b0};
    tbl[1] = '{3'd0, 2'd2, 2'd1, 2'd0, 1'b1, 8'h81, 8'h00, 1'b1};
    tbl[2] = '{3'd1, 2'd3, 2'd0, 2'd1, 1'b0, 8'h00, 8'h81, 1'b1};
    tbl[3] = '{3'd7, 2'd3, 2'd3, 2'd0, 1'b1, 8'h00, 8'hC0, 1'b0};
    tbl[4] = '{3'd4, 2'd0, 2'd1, 2'd3, 1'b0, 8'h00, 8'hBF, 1'b0};
    tbl[5] = '{3'd5, 2'd2, 2'd0, 2'd0, 1'b1, 8'h00, 8'h40, 1'b0};
    tbl[6] = '{3'd6, 2'd1, 2'd3, 2'd0, 1'b1, 8'h00, 8'h80, 1'b0};
    tbl[7] = '{3'd2, 2'd0, 2'd2, 2'd1, 1'b0, 8'h00, 8'hC0, 1'b0};
    tbl[8] = '{3'd3, 2'd2, 2'd0, 2'd0, 1'b1, 8'h0F, 8'h00, 1'b0};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; dbg_addr = '0;
    drive(3'd0, 2'd0, 2'd0, 2'd0, 1'b0, 8'h00);
    in_valid = 1'b0;
    clear_ref();
    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_ops_done", ops_done, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_alu_a", alu_a, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++)
      run_instr(tbl[i].op, tbl[i].rd, tbl[i].rs1, tbl[i].rs2, tbl[i].imm_en, tbl[i].imm,
                1'b1, tbl[i].q, tbl[i].c, 0);

    for (int i = 0; i < 30; i++)
      run_instr(3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                1'b0, 8'h00, 1'b0, $urandom_range(0, 2));

    // Backpressure with a second, dependent instruction waiting upstream.
    @(negedge clk);
    drive(3'd0, 2'd0, 2'd1, 2'd0, 1'b1, 8'h01);
    pa = ref_rf[1] + 8'h01;
    @(negedge clk);
    drive(3'd2, 2'd1, 2'd0, 2'd0, 1'b1, 8'h00);
    @(negedge clk);
    chk("bp_valid", out_valid, 1);
    chk("bp_data", out_data, pa);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_hold_valid", out_valid, 1);
      chk("bp_hold_data", out_data, pa);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_alu_f", alu_f, 3'd0);
    end
    ref_rf[0] = pa;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    ref_ops++;
    chk("bp_ops_once", ops_done, 16'(ref_ops));
    chk("bp_released", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp2_accepted", in_ready, 0);
    chk("bp2_alu_a", alu_a, pa);
    chk("bp2_alu_f", alu_f, 3'd2);
    @(negedge clk);
    chk("bp2_valid", out_valid, 1);
    chk("bp2_data", out_data, pa);
    chk("bp2_rd", out_rd, 1);
    ref_rf[1] = pa;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    ref_ops++;
    chk("bp2_ops", ops_done, 16'(ref_ops));

    // Reset mid-run.
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mrst_in_ready", in_ready, 1);
    chk("mrst_out_valid", out_valid, 0);
    chk("mrst_ops_done", ops_done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    clear_ref();
    for (int i = 0; i < 4; i++) begin
      dbg_addr = 2'(i);
      #1 chk("mrst_dbg", dbg_data, 0);
    end

    // Reset while an instruction is in EXEC.
    @(negedge clk);
    drive(3'd0, 2'd1, 2'd0, 2'd0, 1'b1, 8'h55);
    @(negedge clk);
    in_valid = 1'b0;
    chk("xrst_in_exec", in_ready, 0);
    rst_n = 1'b0;
    #1 chk("xrst_out_valid", out_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    dbg_addr = 2'd1;
    #1;
    chk("xrst_no_write", dbg_data, 0);
    chk("xrst_ops_done", ops_done, 0);
    chk("xrst_in_ready", in_ready, 1);
    chk("xrst_out_valid2", out_valid, 0);
    run_instr(3'd0, 2'd1, 2'd0, 2'd0, 1'b1, 8'h55, 1'b1, 8'h55, 1'b0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
